// File: rtl/wb_mem_pkg.sv
// Shared types and widths for the Wishbone B4 classic memory slave.
package wb_mem_pkg;

  localparam int DATA_W = 64;
  localparam int TAG_W  = 16;
  localparam int SEL_W  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    RSP_ACK = 2'd0,
    RSP_ERR = 2'd1,
    RSP_RTY = 2'd2
  } rsp_t;

endpackage

// File: rtl/wb_mem_slave_if.sv
// Wishbone B4 classic S-side bus between the interconnect stage and the memory slave.
interface wb_mem_slave_if;
  import wb_mem_pkg::*;

  // Handshake: a transfer is requested while CYC_I & STB_I are high and is
  // held until exactly one of ACK_O/ERR_O/RTY_O is seen for one cycle; the
  // master may drop CYC_I/STB_I before that to abandon the transfer.
  logic              CYC_I;
  logic              STB_I;
  logic              WE_I;
  logic [63:0]       ADR_I;
  logic [DATA_W-1:0] DAT_I;
  logic [SEL_W-1:0]  SEL_I;
  logic              LOCK_I;
  logic [TAG_W-1:0]  TGA_I;
  logic [TAG_W-1:0]  TGC_I;
  logic [TAG_W-1:0]  TGD_I;
  logic [DATA_W-1:0] DAT_O;
  logic [TAG_W-1:0]  TGD_O;
  logic              ACK_O;
  logic              ERR_O;
  logic              RTY_O;

  modport master (
    output CYC_I, STB_I, WE_I, ADR_I, DAT_I, SEL_I, LOCK_I, TGA_I, TGC_I, TGD_I,
    input  DAT_O, TGD_O, ACK_O, ERR_O, RTY_O
  );

  modport slave (
    input  CYC_I, STB_I, WE_I, ADR_I, DAT_I, SEL_I, LOCK_I, TGA_I, TGC_I, TGD_I,
    output DAT_O, TGD_O, ACK_O, ERR_O, RTY_O
  );

endinterface

// File: rtl/wb_mem_ram.sv
// Single-port synchronous RAM, 64-bit words, byte write enables, 1-cycle read.
module wb_mem_ram
  import wb_mem_pkg::*;
#(
  parameter int ADDR_BITS = 10
) (
  input  logic                 clk,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic                 we,
  input  logic [SEL_W-1:0]     be,
  input  logic [DATA_W-1:0]    wdata,
  input  logic                 rd,
  output logic [DATA_W-1:0]    rdata
);

  logic [DATA_W-1:0] mem [0:(1<<ADDR_BITS)-1];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < SEL_W; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    if (rd) rdata <= mem[addr];
  end

endmodule

// File: rtl/wb_mem_slave.sv
// Wishbone B4 classic slave over a 64-bit memory with wait states,
// out-of-window ERR and post-write RTY recovery.
module wb_mem_slave
  import wb_mem_pkg::*;
#(
  parameter int          ADDR_BITS   = 10,
  parameter logic [63:0] BASE_ADDR   = 64'h0,
  parameter int          WAIT_STATES = 2,
  parameter int          WR_RECOVERY = 3
) (
  input  logic           clk,
  input  logic           RST_I,
  wb_mem_slave_if.slave  bus,
  output state_t         state_dbg
);

  localparam logic [3:0] WS_LOAD  = 4'(WAIT_STATES);
  localparam logic [7:0] REC_LOAD = 8'(WR_RECOVERY);

  state_t               state;
  logic [3:0]           wait_cnt;
  logic [7:0]           rec_cnt;
  logic [ADDR_BITS-1:0] word_q;
  logic                 we_q;
  logic [DATA_W-1:0]    dat_q;
  logic [SEL_W-1:0]     sel_q;
  logic [TAG_W-1:0]     tgd_q;
  logic                 ack_q, err_q, rty_q, rd_ack_q;
  logic [TAG_W-1:0]     tgd_o_q;

  logic                 req;
  logic [ADDR_BITS-1:0] adr_word;
  logic                 out_of_window;
  logic                 retry_hit;
  rsp_t                 idle_rsp;
  logic [ADDR_BITS-1:0] ram_addr;
  logic                 ram_rd;
  logic                 ram_we;
  logic [DATA_W-1:0]    ram_rdata;
  logic                 unused_ok;

  assign req           = bus.CYC_I & bus.STB_I;
  assign adr_word      = bus.ADR_I[ADDR_BITS+2:3];
  assign out_of_window = bus.ADR_I[63:ADDR_BITS+3] != BASE_ADDR[63:ADDR_BITS+3];
  assign retry_hit     = (rec_cnt != 8'd0) && !bus.LOCK_I;
  assign unused_ok     = ^{bus.TGA_I, bus.TGC_I, bus.ADR_I[2:0]};

  // ERR beats RTY beats ACK.
  always_comb begin
    idle_rsp = RSP_ACK;
    if (out_of_window)  idle_rsp = RSP_ERR;
    else if (retry_hit) idle_rsp = RSP_RTY;
  end

  // Reads are launched one cycle ahead of RESP so the RAM output lines up with ACK.
  always_comb begin
    ram_addr = word_q;
    ram_rd   = 1'b0;
    case (state)
      IDLE: begin
        ram_addr = adr_word;
        ram_rd   = req && !bus.WE_I && (idle_rsp == RSP_ACK) && (WAIT_STATES == 0);
      end
      WAIT:    ram_rd = req && !we_q && (wait_cnt == 4'd1);
      default: ram_rd = 1'b0;
    endcase
  end

  assign ram_we = (state == RESP) && ack_q && we_q && !RST_I;

  wb_mem_ram #(.ADDR_BITS(ADDR_BITS)) u_ram (
    .clk   (clk),
    .addr  (ram_addr),
    .we    (ram_we),
    .be    (sel_q),
    .wdata (dat_q),
    .rd    (ram_rd),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (RST_I) begin
      state    <= IDLE;
      wait_cnt <= '0;
      rec_cnt  <= '0;
      word_q   <= '0;
      we_q     <= 1'b0;
      dat_q    <= '0;
      sel_q    <= '0;
      tgd_q    <= '0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      rty_q    <= 1'b0;
      rd_ack_q <= 1'b0;
      tgd_o_q  <= '0;
    end else begin
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      rty_q    <= 1'b0;
      rd_ack_q <= 1'b0;
      tgd_o_q  <= '0;

      if (ram_we)                rec_cnt <= REC_LOAD;
      else if (rec_cnt != 8'd0)  rec_cnt <= rec_cnt - 8'd1;

      case (state)
        IDLE: begin
          if (req) begin
            word_q <= adr_word;
            we_q   <= bus.WE_I;
            dat_q  <= bus.DAT_I;
            sel_q  <= bus.SEL_I;
            tgd_q  <= bus.TGD_I;
            if (idle_rsp != RSP_ACK || WAIT_STATES == 0) begin
              state    <= RESP;
              ack_q    <= (idle_rsp == RSP_ACK);
              err_q    <= (idle_rsp == RSP_ERR);
              rty_q    <= (idle_rsp == RSP_RTY);
              rd_ack_q <= (idle_rsp == RSP_ACK) && !bus.WE_I;
              tgd_o_q  <= bus.TGD_I;
            end else begin
              state    <= WAIT;
              wait_cnt <= WS_LOAD;
            end
          end
        end
        WAIT: begin
          wait_cnt <= wait_cnt - 4'd1;
          if (!req) begin
            state <= IDLE;
          end else if (wait_cnt == 4'd1) begin
            state    <= RESP;
            ack_q    <= 1'b1;
            rd_ack_q <= !we_q;
            tgd_o_q  <= tgd_q;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ACK_O = ack_q;
  assign bus.ERR_O = err_q;
  assign bus.RTY_O = rty_q;
  assign bus.TGD_O = tgd_o_q;
  assign bus.DAT_O = rd_ack_q ? ram_rdata : '0;
  assign state_dbg = state;

endmodule

// File: tb/tb_wb_mem_slave.sv
// Directed and randomized checks of wb_mem_slave against a transaction-level memory model.
module tb_wb_mem_slave;
  import wb_mem_pkg::*;

  localparam int          ADDR_BITS   = 10;
  localparam logic [63:0] BASE_ADDR   = 64'h0;
  localparam int          WAIT_STATES = 2;
  localparam int          WR_RECOVERY = 3;
  localparam logic [63:0] WINDOW      = 64'd8 << ADDR_BITS;
  localparam int          K_NONE = -1, K_ACK = 0, K_ERR = 1, K_RTY = 2;

  logic clk = 1'b0;
  logic RST_I = 1'b1;
  state_t state_dbg;
  wb_mem_slave_if bus();

  wb_mem_slave #(
    .ADDR_BITS(ADDR_BITS), .BASE_ADDR(BASE_ADDR),
    .WAIT_STATES(WAIT_STATES), .WR_RECOVERY(WR_RECOVERY)
  ) dut (
    .clk(clk), .RST_I(RST_I), .bus(bus), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int n_asserts = 0;
  int n_fail    = 0;
  logic [63:0] model_mem [0:(1<<ADDR_BITS)-1];
  int last_wr_ack = -1000;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_asserts++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic bus_idle();
    bus.CYC_I = 1'b0; bus.STB_I = 1'b0; bus.WE_I = 1'b0; bus.ADR_I = '0;
    bus.DAT_I = '0; bus.SEL_I = '0; bus.LOCK_I = 1'b0;
    bus.TGA_I = '0; bus.TGC_I = '0; bus.TGD_I = '0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("idle_term", 64'({bus.ACK_O, bus.ERR_O, bus.RTY_O}), 64'd0);
      chk("idle_dat", bus.DAT_O, 64'd0);
      chk("idle_tgd", 64'(bus.TGD_O), 64'd0);
    end
  endtask

  // Called at a negedge; the request is sampled on the following rising edge.
  task automatic xfer(input logic we, input logic [63:0] adr, input logic [63:0] dat,
                      input logic [7:0] sel, input logic [15:0] tgd, input logic lock,
                      output int kind, output logic [63:0] got_dat);
    int s, w, exp_kind, exp_lat, lat;
    logic [63:0] exp_dat;
    s = cyc;
    w = int'(adr[ADDR_BITS+2:3]);
    if (adr < BASE_ADDR || adr >= BASE_ADDR + WINDOW)                        exp_kind = K_ERR;
    else if (!lock && (s - last_wr_ack) >= 1 && (s - last_wr_ack) <= WR_RECOVERY) exp_kind = K_RTY;
    else                                                                      exp_kind = K_ACK;
    exp_lat = (exp_kind == K_ACK) ? 1 + WAIT_STATES : 1;
    exp_dat = (exp_kind == K_ACK && !we) ? model_mem[w] : 64'd0;

    bus.CYC_I = 1'b1; bus.STB_I = 1'b1; bus.WE_I = we; bus.ADR_I = adr;
    bus.DAT_I = dat; bus.SEL_I = sel; bus.LOCK_I = lock; bus.TGD_I = tgd;
    bus.TGA_I = 16'($urandom); bus.TGC_I = 16'($urandom);

    kind = K_NONE; lat = 0; got_dat = '0;
    for (int k = 1; k <= 20 && kind == K_NONE; k++) begin
      @(negedge clk);
      if (bus.ACK_O || bus.ERR_O || bus.RTY_O) begin
        lat     = k;
        kind    = bus.ACK_O ? K_ACK : (bus.ERR_O ? K_ERR : K_RTY);
        got_dat = bus.DAT_O;
        chk("term_onehot", 64'(32'(bus.ACK_O) + 32'(bus.ERR_O) + 32'(bus.RTY_O)), 64'd1);
        chk("term_dat", bus.DAT_O, exp_dat);
        chk("term_tgd", 64'(bus.TGD_O), 64'(tgd));
      end else begin
        chk("wait_dat", bus.DAT_O, 64'd0);
        chk("wait_tgd", 64'(bus.TGD_O), 64'd0);
      end
    end
    bus_idle();
    chk("term_seen", 64'(kind != K_NONE), 64'd1);
    chk("term_kind", 64'(kind), 64'(exp_kind));
    chk("term_lat", 64'(lat), 64'(exp_lat));

    if (exp_kind == K_ACK && we) begin
      for (int i = 0; i < 8; i++)
        if (sel[i]) model_mem[w][8*i +: 8] = dat[8*i +: 8];
      last_wr_ack = s + exp_lat;
    end
    idle_cycles(1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int          kind;
    logic [63:0] d, old80, adr;
    bus_idle();

    // Reset
    RST_I = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_term", 64'({bus.ACK_O, bus.ERR_O, bus.RTY_O}), 64'd0);
    chk("rst_dat", bus.DAT_O, 64'd0);
    chk("rst_tgd", 64'(bus.TGD_O), 64'd0);
    chk("rst_state", 64'(state_dbg), 64'(IDLE));
    RST_I = 1'b0;
    idle_cycles(2);

    // Preload the words used below so every read has a known value
    for (int w = 0; w < 17; w++) begin
      xfer(1'b1, 64'(w) << 3, {$urandom, $urandom}, 8'hFF, 16'h0, 1'b0, kind, d);
      idle_cycles(3);
    end
    xfer(1'b1, 64'h1FF8, 64'h0BAD_F00D_1234_5678, 8'hFF, 16'h0, 1'b0, kind, d);
    idle_cycles(3);
    xfer(1'b0, 64'h1FF8, 64'h0, 8'h00, 16'h0, 1'b0, kind, d);
    chk("last_word", d, 64'h0BAD_F00D_1234_5678);
    idle_cycles(3);

    // Full write then read
    xfer(1'b1, 64'h40, 64'hDEAD_BEEF_0123_4567, 8'hFF, 16'h0, 1'b0, kind, d);
    idle_cycles(3);
    xfer(1'b0, 64'h40, 64'h0, 8'h00, 16'h0, 1'b0, kind, d);
    chk("rd_full", d, 64'hDEAD_BEEF_0123_4567);
    idle_cycles(3);

    // Partial byte-lane write
    xfer(1'b1, 64'h40, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, 16'h0, 1'b0, kind, d);
    idle_cycles(3);
    xfer(1'b0, 64'h40, 64'h0, 8'h00, 16'h0, 1'b0, kind, d);
    chk("rd_partial", d, 64'hDEAD_BEEF_FFFF_FFFF);
    idle_cycles(3);

    // Out-of-window write gives ERR and leaves memory alone
    xfer(1'b1, 64'h2000, 64'h1111_2222_3333_4444, 8'hFF, 16'h0, 1'b0, kind, d);
    chk("oow_kind", 64'(kind), 64'(K_ERR));
    xfer(1'b0, 64'h0, 64'h0, 8'h00, 16'h0, 1'b0, kind, d);
    chk("oow_mem0", d, model_mem[0]);

    // Write recovery retry, lock override, then retry window expired
    idle_cycles(3);
    xfer(1'b1, 64'h48, 64'h5555_AAAA_5555_AAAA, 8'hFF, 16'h0, 1'b0, kind, d);
    xfer(1'b0, 64'h48, 64'h0, 8'h00, 16'h0, 1'b0, kind, d);
    chk("rec_rty", 64'(kind), 64'(K_RTY));
    xfer(1'b0, 64'h48, 64'h0, 8'h00, 16'h0, 1'b1, kind, d);
    chk("rec_lock_ack", 64'(kind), 64'(K_ACK));
    chk("rec_lock_dat", d, 64'h5555_AAAA_5555_AAAA);
    idle_cycles(4);
    xfer(1'b0, 64'h48, 64'h0, 8'h00, 16'h0, 1'b0, kind, d);
    chk("rec_done_ack", 64'(kind), 64'(K_ACK));
    idle_cycles(3);

    // Data tag echo
    xfer(1'b0, 64'h40, 64'h0, 8'h00, 16'hA5A5, 1'b0, kind, d);
    chk("tgd_kind", 64'(kind), 64'(K_ACK));
    idle_cycles(3);

    // Abort during WAIT
    old80 = model_mem[16];
    bus.CYC_I = 1'b1; bus.STB_I = 1'b1; bus.WE_I = 1'b1; bus.ADR_I = 64'h80;
    bus.DAT_I = ~old80; bus.SEL_I = 8'hFF;
    @(negedge clk);
    chk("abort_in_wait", 64'(state_dbg), 64'(WAIT));
    bus_idle();
    idle_cycles(4);
    xfer(1'b0, 64'h80, 64'h0, 8'h00, 16'h0, 1'b0, kind, d);
    chk("abort_mem", d, old80);
    idle_cycles(3);

    // Reset while in WAIT
    bus.CYC_I = 1'b1; bus.STB_I = 1'b1; bus.WE_I = 1'b0; bus.ADR_I = 64'h40;
    bus.TGD_I = 16'h1234;
    @(negedge clk);
    RST_I = 1'b1;
    @(negedge clk);
    chk("rstw_term", 64'({bus.ACK_O, bus.ERR_O, bus.RTY_O}), 64'd0);
    chk("rstw_dat", bus.DAT_O, 64'd0);
    chk("rstw_tgd", 64'(bus.TGD_O), 64'd0);
    chk("rstw_state", 64'(state_dbg), 64'(IDLE));
    RST_I = 1'b0;
    bus_idle();
    last_wr_ack = -1000;
    idle_cycles(3);

    // Randomized traffic
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        adr = {$urandom, $urandom};
        adr[13 + $urandom_range(0, 50)] = 1'b1;
      end else begin
        adr = (64'($urandom_range(0, 16)) << 3) | 64'($urandom_range(0, 7));
      end
      xfer(1'($urandom_range(0, 1)), adr, {$urandom, $urandom}, 8'($urandom),
           16'($urandom), ($urandom_range(0, 3) == 0), kind, d);
      idle_cycles($urandom_range(0, 4));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_mem_slave.md
Name: wb_mem_slave

Overview:
- Wishbone B4 classic-cycle slave. Holds a 64-bit-wide synchronous memory and terminates the S-side bus that the master-to-slave interconnect stage drives.
- Consumes the stage's SCYC/SSTB/SWE/SADR/SDAT/SSEL/SLOCK/STGA/STGC/STGD outputs.
- Produces SACK/SERR/SRTY/SDAT/STGD back to that stage.
- Supports programmable wait states, address-range error, and write-recovery retry. This gives the bench ACK, ERR and RTY terminations from one block.

Parameters:
- ADDR_BITS, 10, log2 of memory depth in 64-bit words (1024 words).
- BASE_ADDR, 64'h0, byte base address of the window; must be aligned to 8*2^ADDR_BITS.
- WAIT_STATES, 2, extra cycles inserted before ACK on a good access (0..15).
- WR_RECOVERY, 3, cycles after a write ACK during which any new access gets RTY (0 disables retry).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- RST_I  in  1  synchronous active-high reset.
- CYC_I  in  1  bus cycle in progress.
- STB_I  in  1  strobe / valid transfer.
- WE_I  in  1  1 = write, 0 = read.
- ADR_I  in  64  byte address; bits [2:0] are ignored.
- DAT_I  in  64  write data.
- SEL_I  in  8  byte lanes; SEL_I[n] covers DAT bits [8n+7:8n].
- LOCK_I  in  1  locked cycle; suppresses retry while held.
- TGA_I  in  16  address tag; carried but unused.
- TGC_I  in  16  cycle tag; carried but unused.
- TGD_I  in  16  data tag.
- DAT_O  out  64  read data.
- TGD_O  out  16  data tag echo.
- ACK_O  out  1  normal termination.
- ERR_O  out  1  error termination.
- RTY_O  out  1  retry termination.

Behaviour:
- Reset: all outputs are 0. FSM goes to IDLE. Wait counter and recovery counter are 0. Memory contents are not reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE: when CYC_I & STB_I, capture ADR_I, WE_I, DAT_I, SEL_I and TGD_I, then decode:
  - Out of window (ADR_I[63:ADDR_BITS+3] != BASE_ADDR[63:ADDR_BITS+3]) -> RESP, ERR.
  - Else if recovery counter != 0 and !LOCK_I -> RESP, RTY.
  - Else if WAIT_STATES == 0 -> RESP, ACK.
  - Else -> WAIT with counter = WAIT_STATES.
- WAIT: decrement the counter each cycle. When the counter reaches 1, go to RESP with ACK.
- RESP: exactly one of ACK_O/ERR_O/RTY_O is high for one cycle. The next state is always IDLE.
- Latency: the request is sampled in cycle N and the termination is high in cycle N+1+WAIT_STATES. ERR and RTY are always returned in cycle N+1.
- Back-to-back transfers have at least one IDLE cycle between terminations; STB held high is re-sampled in IDLE.
- Writes: the memory word at ADR_I[ADDR_BITS+2:3] is updated in the ACK cycle, per SEL_I byte lane only. No write happens on ERR or RTY.
- Write ACK loads the recovery counter with WR_RECOVERY. The counter decrements every cycle down to 0.
- Reads: DAT_O carries the word (all 8 lanes, SEL_I ignored) during the ACK cycle. DAT_O is 0 in every other cycle, including ERR and RTY cycles.
- TGD_O equals the captured TGD_I in any RESP cycle, and is 0 otherwise.
- Abort: if CYC_I or STB_I is low during WAIT, return to IDLE next cycle with no termination and no memory write. The recovery counter is unaffected.
- LOCK_I: while high, the RTY decode is skipped and the access proceeds as normal.
- Simultaneous events: RST_I overrides everything. ERR takes priority over RTY, and RTY over ACK.
- Read-after-write to the same address returns the new data (the write completed in the earlier ACK cycle).

Decomposition:
- Package wb_mem_pkg holds:
  - state enum {IDLE, WAIT, RESP}.
  - response-kind enum {RSP_ACK, RSP_ERR, RSP_RTY}.
  - Localparams for data width 64, tag width 16 and SEL width 8.
- Sub-module wb_mem_ram is a single-port synchronous RAM with byte-write enables, a 2^ADDR_BITS x 64 array and 1-cycle read. The read is issued on entry to the final cycle so the data aligns with ACK.
- FSM, decode and counters live in the top module.

Test Plan:
- Reset, then write 64'hDEAD_BEEF_0123_4567 to 0x40 with SEL=8'hFF, then read 0x40 -> ACK at cycle N+3 (WAIT_STATES=2) and DAT_O=64'hDEAD_BEEF_0123_4567.
- Write 64'hFFFF_FFFF_FFFF_FFFF with SEL=8'h0F over that word -> a read returns 64'hDEAD_BEEF_FFFF_FFFF.
- Access to ADR 64'h2000 (outside the 8 KiB window) -> ERR_O high at N+1, ACK_O=0, DAT_O=0, and a subsequent read of 0x0 shows memory unchanged.
- Write ACK, then a read issued 1 cycle later -> RTY_O at N+1. The same read with LOCK_I=1 -> ACK. After waiting more than 3 cycles, the read without lock -> ACK.
- TGD_I=16'hA5A5 on a read -> TGD_O=16'hA5A5 only in the ACK cycle, and 0 before and after.
- Drop CYC_I during WAIT on a write to 0x80 -> no termination and memory unchanged. Assert RST_I mid-WAIT -> all outputs 0 next cycle and FSM in IDLE.
